// File: rtl/wb_trace_tx.sv
// Retirement trace transmitter: FIFOs MEM/WB writebacks, emits 5x32b records (HDR, PC_LO, PC_HI, D_LO, D_HI).
// Latency: wb_valid at edge E0 -> HDR presented after E1; one word per cycle when out_ready is held high.
// Backpressure: words hold while !out_ready; full FIFO drops records (sticky overflow, drop_count). Option: WB_TRACE_X0_FILTER_EN.
module wb_trace_tx #(
    parameter int DEPTH = 4,
    parameter int SEQ_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wb_valid,
    input  logic [63:0]              wb_pc,
    input  logic [4:0]               wb_rd,
    input  logic [63:0]              wb_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_word,
    output logic                     out_last,
    output logic                     overflow,
    output logic [7:0]               drop_count,
    output logic [$clog2(DEPTH):0]   fifo_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [SEQ_W-1:0] seq;
        logic [4:0]       rd;
        logic [63:0]      pc;
        logic [63:0]      data;
    } rec_t;

    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_PC_LO, S_PC_HI, S_D_LO, S_D_HI
    } state_t;

    state_t           state_q, state_d;
    rec_t             mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [SEQ_W-1:0] seq_q;
    logic [31:0]      word_q, word_d;
    logic             last_q, last_d;
    logic             overflow_q;
    logic [7:0]       drop_q;

    logic take, full, pop, push, drop;
    rec_t head, next_head, new_rec;

`ifdef WB_TRACE_X0_FILTER_EN
    assign take = wb_valid && (wb_rd != 5'd0);
`else
    assign take = wb_valid;
`endif

    assign full = (count_q == CW'(DEPTH));
    assign pop  = (state_q == S_D_HI) && out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push = take && (!full || pop);
    assign drop = take && full && !pop;

    assign head      = mem_q[rd_ptr_q];
    assign next_head = mem_q[rd_ptr_q + AW'(1)];
    assign new_rec   = '{seq: seq_q, rd: wb_rd, pc: wb_pc, data: wb_data};

    function automatic logic [31:0] hdr_word(input rec_t r);
        return {8'hA5, 3'b000, r.rd, r.seq};
    endfunction

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= new_rec;
        end
    end

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        last_d  = last_q;
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    state_d = S_HDR;
                    word_d  = hdr_word(head);
                    last_d  = 1'b0;
                end
            end
            S_HDR: if (out_ready) begin
                state_d = S_PC_LO;
                word_d  = head.pc[31:0];
            end
            S_PC_LO: if (out_ready) begin
                state_d = S_PC_HI;
                word_d  = head.pc[63:32];
            end
            S_PC_HI: if (out_ready) begin
                state_d = S_D_LO;
                word_d  = head.data[31:0];
            end
            S_D_LO: if (out_ready) begin
                state_d = S_D_HI;
                word_d  = head.data[63:32];
                last_d  = 1'b1;
            end
            S_D_HI: if (out_ready) begin
                last_d = 1'b0;
                if (count_q > CW'(1)) begin
                    state_d = S_HDR;
                    word_d  = hdr_word(next_head);
                end else begin
                    state_d = S_IDLE;
                    word_d  = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                word_d  = '0;
                last_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            word_q     <= '0;
            last_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            seq_q      <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            last_q  <= last_d;
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            // Dropped records still consume a sequence number so the host sees the gap.
            if (take) seq_q <= seq_q + SEQ_W'(1);
            if (drop) begin
                overflow_q <= 1'b1;
                if (drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
            end
        end
    end

    assign out_valid  = (state_q != S_IDLE);
    assign out_word   = word_q;
    assign out_last   = last_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_q;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_wb_trace_tx.sv
// Directed self-checking bench for wb_trace_tx (DEPTH=4).
module tb_wb_trace_tx;
    logic        clk = 1'b0;
    logic        reset;
    logic        wb_valid;
    logic [63:0] wb_pc;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_word;
    logic        out_last;
    logic        overflow;
    logic [7:0]  drop_count;
    logic [2:0]  fifo_count;

    int checks   = 0;
    int failures = 0;

    wb_trace_tx #(.DEPTH(4), .SEQ_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .wb_valid   (wb_valid),
        .wb_pc      (wb_pc),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_word   (out_word),
        .out_last   (out_last),
        .overflow   (overflow),
        .drop_count (drop_count),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        reset = 1'b1;
        step();
    endtask

    task automatic push(input logic [4:0] rd, input logic [63:0] pc, input logic [63:0] data);
        wb_valid = 1'b1;
        wb_rd    = rd;
        wb_pc    = pc;
        wb_data  = data;
        step();
        wb_valid = 1'b0;
    endtask

    function automatic logic [31:0] hdr(input logic [4:0] rd, input logic [15:0] seq);
        return {8'hA5, 3'b000, rd, seq};
    endfunction

    // Waits (bounded) for a word, checks it, then lets the handshake happen.
    task automatic expect_word(input string tag, input logic [31:0] w, input logic l);
        int n = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        check({tag, "_valid"}, 64'(out_valid), 64'(1));
        check(tag, 64'(out_word), 64'(w));
        check({tag, "_last"}, 64'(out_last), 64'(l));
        step();
    endtask

    task automatic drain_record(input string tag, input logic [4:0] rd, input logic [15:0] seq,
                                input logic [63:0] pc, input logic [63:0] data);
        expect_word({tag, "_hdr"},  hdr(rd, seq), 1'b0);
        expect_word({tag, "_pclo"}, pc[31:0],     1'b0);
        expect_word({tag, "_pchi"}, pc[63:32],    1'b0);
        expect_word({tag, "_dlo"},  data[31:0],   1'b0);
        expect_word({tag, "_dhi"},  data[63:32],  1'b1);
    endtask

    initial begin
        reset     = 1'b0;
        wb_valid  = 1'b0;
        wb_pc     = '0;
        wb_rd     = '0;
        wb_data   = '0;
        out_ready = 1'b0;
        @(negedge clk);

        check("rst_valid", 64'(out_valid),  64'(0));
        check("rst_word",  64'(out_word),   64'(0));
        check("rst_last",  64'(out_last),   64'(0));
        check("rst_ovf",   64'(overflow),   64'(0));
        check("rst_drop",  64'(drop_count), 64'(0));
        check("rst_count", 64'(fifo_count), 64'(0));
        reset = 1'b1;
        step();

        // Single record, latency and word order
        out_ready = 1'b1;
        push(5'd5, 64'h10, 64'hDEADBEEF);
        check("lat_count_e0", 64'(fifo_count), 64'(1));
        check("lat_valid_e0", 64'(out_valid),  64'(0));
        step();
        check("lat_valid_e1", 64'(out_valid), 64'(1));
        expect_word("r0_hdr",  32'hA5050000, 1'b0);
        expect_word("r0_pclo", 32'h00000010, 1'b0);
        expect_word("r0_pchi", 32'h00000000, 1'b0);
        expect_word("r0_dlo",  32'hDEADBEEF, 1'b0);
        expect_word("r0_dhi",  32'h00000000, 1'b1);
        check("r0_idle_valid", 64'(out_valid),  64'(0));
        check("r0_idle_count", 64'(fifo_count), 64'(0));

        // Backpressure during PC_HI
        push(5'd7, 64'h11223344_55667788, 64'hCAFEBABE_01234567);
        expect_word("bp_hdr",  32'hA5070001, 1'b0);
        expect_word("bp_pclo", 32'h55667788, 1'b0);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_hold_word",  64'(out_word),  64'h11223344);
            check("bp_hold_valid", 64'(out_valid), 64'(1));
            check("bp_hold_last",  64'(out_last),  64'(0));
        end
        out_ready = 1'b1;
        expect_word("bp_pchi", 32'h11223344, 1'b0);
        expect_word("bp_dlo",  32'h01234567, 1'b0);
        expect_word("bp_dhi",  32'hCAFEBABE, 1'b1);

        // Overflow: six pushes into a stalled DEPTH=4 FIFO
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) push(5'(i + 1), 64'(i * 16), 64'(100 + i));
        check("ovf_count", 64'(fifo_count), 64'(4));
        check("ovf_flag",  64'(overflow),   64'(1));
        check("ovf_drop",  64'(drop_count), 64'(2));
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) drain_record("ovf", 5'(i + 1), 16'(i), 64'(i * 16), 64'(100 + i));
        check("ovf_empty", 64'(fifo_count), 64'(0));
        check("ovf_sticky", 64'(overflow),  64'(1));

        // Push on the D_HI handshake of a full FIFO is accepted
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(5'(i + 8), 64'(32'h1000 + i), 64'(32'h2000 + i));
        check("fp_count_full", 64'(fifo_count), 64'(4));
        out_ready = 1'b1;
        expect_word("fp_hdr",  hdr(5'd8, 16'd6), 1'b0);
        expect_word("fp_pclo", 32'h1000, 1'b0);
        expect_word("fp_pchi", 32'h0, 1'b0);
        expect_word("fp_dlo",  32'h2000, 1'b0);
        check("fp_dhi_word", 64'(out_word), 64'(0));
        check("fp_dhi_last", 64'(out_last), 64'(1));
        push(5'd20, 64'h3000, 64'h4000);
        check("fp_count_same", 64'(fifo_count), 64'(4));
        check("fp_no_drop",    64'(drop_count), 64'(2));
        for (int i = 1; i < 4; i++) drain_record("fp", 5'(i + 8), 16'(6 + i), 64'(32'h1000 + i), 64'(32'h2000 + i));
        drain_record("fp_new", 5'd20, 16'd10, 64'h3000, 64'h4000);
        check("fp_empty", 64'(fifo_count), 64'(0));

        // Reset during D_LO abandons the record
        push(5'd9, 64'h50, 64'h60);
        expect_word("mr_hdr",  hdr(5'd9, 16'd11), 1'b0);
        expect_word("mr_pclo", 32'h50, 1'b0);
        expect_word("mr_pchi", 32'h0, 1'b0);
        check("mr_dlo", 64'(out_word), 64'h60);
        reset = 1'b0;
        #1;
        check("mr_valid", 64'(out_valid),  64'(0));
        check("mr_word",  64'(out_word),   64'(0));
        check("mr_last",  64'(out_last),   64'(0));
        check("mr_count", 64'(fifo_count), 64'(0));
        check("mr_ovf",   64'(overflow),   64'(0));
        check("mr_drop",  64'(drop_count), 64'(0));
        @(negedge clk);
        reset = 1'b1;
        step();
        push(5'd10, 64'h70, 64'h80);
        drain_record("mr_next", 5'd10, 16'd0, 64'h70, 64'h80);

        // Writes to x0
        push(5'd0, 64'h90, 64'hA0);
`ifdef WB_TRACE_X0_FILTER_EN
        check("x0_count", 64'(fifo_count), 64'(0));
        step();
        check("x0_valid", 64'(out_valid), 64'(0));
        push(5'd1, 64'hB0, 64'hC0);
        drain_record("x0_after", 5'd1, 16'd1, 64'hB0, 64'hC0);
`else
        drain_record("x0_traced", 5'd0, 16'd1, 64'h90, 64'hA0);
        push(5'd1, 64'hB0, 64'hC0);
        drain_record("x0_after", 5'd1, 16'd2, 64'hB0, 64'hC0);
`endif

        // Sequence wrap; dropped records also advance seq
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 65535; i++) push(5'd3, 64'(i), 64'd0);
        check("wrap_drop_sat", 64'(drop_count), 64'(255));
        check("wrap_ovf",      64'(overflow),   64'(1));
        check("wrap_count",    64'(fifo_count), 64'(4));
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) drain_record("wrap_head", 5'd3, 16'(i), 64'(i), 64'd0);
        push(5'd4, 64'hAB, 64'hCD);
        drain_record("wrap_ffff", 5'd4, 16'hFFFF, 64'hAB, 64'hCD);
        push(5'd6, 64'hEF, 64'h12);
        drain_record("wrap_zero", 5'd6, 16'h0000, 64'hEF, 64'h12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
